// File: rtl/wf_pkg.sv
// Shared types and constants for the waveform playback controller.
package wf_pkg;

    localparam int unsigned WF_ADDR_W     = 9;
    localparam int unsigned WF_DATA_W     = 16;
    localparam int unsigned WF_DIV_W      = 16;
    localparam int unsigned WF_MIN_PERIOD = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } wf_state_e;

endpackage

// File: rtl/wf_period_timer.sv
// Sample-period countdown: ticks when the count is zero, then reloads max(period,3)-1.
module wf_period_timer
    import wf_pkg::*;
#(
    parameter int unsigned DIV_W = WF_DIV_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_period,
    output logic             o_tick
);

    localparam logic [DIV_W-1:0] MIN_RELOAD = DIV_W'(WF_MIN_PERIOD - 1);
    localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_reload;

    always_comb begin
        w_reload = i_period - ONE;
        if (i_period < DIV_W'(WF_MIN_PERIOD)) begin
            w_reload = MIN_RELOAD;
        end
    end

    assign o_tick = i_en && (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= w_reload;
        end else if (i_en) begin
            r_cnt <= r_cnt - ONE;
        end
    end

endmodule

// File: rtl/wf_play_ctrl.sv
// Waveform playback controller: paced table fetches sharing one RAM port with host writes.
// Optional macro WF_LOOP_EN enables multi-pass playback via i_loop_cnt (0 = infinite).
module wf_play_ctrl
    import wf_pkg::*;
#(
    parameter int unsigned ADDR_W = WF_ADDR_W,
    parameter int unsigned DATA_W = WF_DATA_W,
    parameter int unsigned DIV_W  = WF_DIV_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W:0]   i_len,
    input  logic [DIV_W-1:0]  i_period,
    input  logic [15:0]       i_loop_cnt,
    input  logic              i_host_wr_req,
    input  logic [ADDR_W-1:0] i_host_wr_addr,
    input  logic [DATA_W-1:0] i_host_wr_data,
    output logic              o_host_wr_ack,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_sample_vld,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_len_err,
    output logic [ADDR_W-1:0] o_sample_idx,
    output logic [15:0]       o_loop_idx
);

    localparam logic [ADDR_W:0]   LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    wf_state_e         r_state;
    wf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_sample_idx;
    logic [15:0]       r_loop_idx;
    logic [DATA_W-1:0] r_sample;
    logic              r_stop;
    logic              r_fetch_pend;
    logic              r_fetch_last;
    logic              r_vld;
    logic              r_done;
    logic              r_len_err;

    logic w_tick;
    logic w_fetch;
    logic w_grant;
    logic w_len_ok;
    logic w_accept;
    logic w_abort;
    logic w_last_entry;
    logic w_last_pass;

    wf_period_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (r_state != StRun),
        .i_en     (r_state == StRun),
        .i_period (i_period),
        .o_tick   (w_tick)
    );

    assign w_len_ok     = (i_len != '0) && (i_len <= LEN_MAX);
    assign w_last_entry = ({1'b0, r_idx} == (i_len - LEN_ONE));
    assign w_abort      = (r_state == StRun) && i_abort;

`ifdef WF_LOOP_EN
    assign w_last_pass = (i_loop_cnt != '0) && ((r_loop_idx + 16'd1) == i_loop_cnt);
`else
    logic w_unused_loop_cnt;
    assign w_unused_loop_cnt = ^i_loop_cnt;
    assign w_last_pass       = 1'b1;
`endif

    // Fetch owns the port; gating with reset releases the port while reset is held.
    assign w_fetch = (r_state == StRun) && w_tick && !r_stop;
    assign w_grant = i_rst && i_host_wr_req && !w_fetch;

    always_comb begin
        o_ram_en   = w_fetch || w_grant;
        o_ram_we   = w_grant;
        o_ram_addr = '0;
        o_ram_din  = '0;
        if (w_fetch) begin
            o_ram_addr = r_idx;
        end else if (w_grant) begin
            o_ram_addr = i_host_wr_addr;
            o_ram_din  = i_host_wr_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_accept    = w_len_ok;
                    w_state_nxt = w_len_ok ? StRun : StDone;
                end
            end
            StRun: begin
                if (i_abort || (r_vld && r_done)) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (!i_start) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            r_sample_idx <= '0;
            r_loop_idx   <= '0;
            r_sample     <= '0;
            r_stop       <= 1'b0;
            r_fetch_pend <= 1'b0;
            r_fetch_last <= 1'b0;
            r_vld        <= 1'b0;
            r_done       <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == StIdle) && i_start) begin
                r_len_err <= !w_len_ok;
            end
            if (w_accept) begin
                r_idx        <= '0;
                r_sample_idx <= '0;
                r_loop_idx   <= '0;
                r_stop       <= 1'b0;
            end else if (w_fetch) begin
                r_sample_idx <= r_idx;
                if (w_last_entry) begin
                    r_idx      <= '0;
                    r_loop_idx <= r_loop_idx + 16'd1;
                    r_stop     <= w_last_pass;
                end else begin
                    r_idx <= r_idx + IDX_ONE;
                end
            end
            // Two-stage fetch pipeline: RAM read latency, then capture; abort kills both.
            r_fetch_pend <= w_fetch && !w_abort;
            r_fetch_last <= w_fetch && w_last_entry && w_last_pass;
            r_vld        <= r_fetch_pend && !w_abort;
            r_done       <= r_fetch_pend && r_fetch_last && !w_abort;
            if (r_fetch_pend && !w_abort) begin
                r_sample <= i_ram_dout;
            end
        end
    end

    assign o_host_wr_ack = w_grant;
    assign o_sample      = r_sample;
    assign o_sample_vld  = r_vld;
    assign o_busy        = (r_state == StRun);
    assign o_done        = r_done;
    assign o_len_err     = r_len_err;
    assign o_sample_idx  = r_sample_idx;
    assign o_loop_idx    = r_loop_idx;

endmodule

// File: tb/tb_wf_play_ctrl.sv
// Bench for wf_play_ctrl: table-driven playback runs plus collision, abort and reset sequences.
module tb_wf_play_ctrl;

`ifdef WF_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic        i_abort;
    logic [9:0]  i_len;
    logic [15:0] i_period;
    logic [15:0] i_loop_cnt;
    logic        i_host_wr_req;
    logic [8:0]  i_host_wr_addr;
    logic [15:0] i_host_wr_data;
    logic        o_host_wr_ack;
    logic        o_ram_en;
    logic        o_ram_we;
    logic [8:0]  o_ram_addr;
    logic [15:0] o_ram_din;
    logic [15:0] ram_dout;
    logic [15:0] o_sample;
    logic        o_sample_vld;
    logic        o_busy;
    logic        o_done;
    logic        o_len_err;
    logic [8:0]  o_sample_idx;
    logic [15:0] o_loop_idx;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [15:0] mem [0:511];
    logic [95:0] w_outs;

    typedef struct {
        logic [9:0]  len;
        logic [15:0] period;
        logic [15:0] loop;
        int          sp;
        bit          err;
    } vec_t;

    vec_t vecs [8];

    wf_play_ctrl u_dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_len          (i_len),
        .i_period       (i_period),
        .i_loop_cnt     (i_loop_cnt),
        .i_host_wr_req  (i_host_wr_req),
        .i_host_wr_addr (i_host_wr_addr),
        .i_host_wr_data (i_host_wr_data),
        .o_host_wr_ack  (o_host_wr_ack),
        .o_ram_en       (o_ram_en),
        .o_ram_we       (o_ram_we),
        .o_ram_addr     (o_ram_addr),
        .o_ram_din      (o_ram_din),
        .i_ram_dout     (ram_dout),
        .o_sample       (o_sample),
        .o_sample_vld   (o_sample_vld),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_len_err      (o_len_err),
        .o_sample_idx   (o_sample_idx),
        .o_loop_idx     (o_loop_idx)
    );

    assign w_outs = {23'd0, o_host_wr_ack, o_ram_en, o_ram_we, o_ram_addr, o_ram_din, o_sample,
                     o_sample_vld, o_busy, o_done, o_len_err, o_sample_idx, o_loop_idx};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (o_ram_en) begin
            if (o_ram_we) mem[o_ram_addr] <= o_ram_din;
            else          ram_dout <= mem[o_ram_addr];
        end
    end

    function automatic logic [15:0] exp_val(input int k);
        return 16'((k * 37 + 5) & 32'h0000_ffff);
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    task automatic host_write(input int addr, input logic [15:0] data, input bit chk);
        @(negedge clk);
        i_host_wr_req  = 1'b1;
        i_host_wr_addr = 9'(addr);
        i_host_wr_data = data;
        #1;
        if (chk) check("idle_ack", {o_host_wr_ack, o_ram_en, o_ram_we}, 3'b111);
        @(negedge clk);
        i_host_wr_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  s;
        int  nstr;
        int  ndone;
        int  nfetch;
        int  nbusy;
        int  last_vld;
        int  exp_n;
        int  exp_lp;
        bit  fin;
        bit  done_seen;
        exp_n  = LOOP_EN ? int'(v.len) * int'(v.loop) : int'(v.len);
        exp_lp = LOOP_EN ? int'(v.loop) : 1;
        @(negedge clk);
        i_len      = v.len;
        i_period   = v.period;
        i_loop_cnt = v.loop;
        i_start    = 1'b1;
        s          = cyc;
        nstr = 0; ndone = 0; nfetch = 0; nbusy = 0; last_vld = 0;
        fin = 1'b0; done_seen = 1'b0;
        if (v.err) begin
            repeat (6) begin
                @(negedge clk);
                if (o_ram_en && !o_ram_we) nfetch++;
                if (o_busy) nbusy++;
                if (o_done || o_sample_vld) ndone++;
            end
            check("err_flag", o_len_err, 1);
            check("err_fetch", nfetch, 0);
            check("err_busy", nbusy, 0);
            check("err_nodone", ndone, 0);
        end else begin
            for (int t = 0; t < 4000 && !fin; t++) begin
                @(negedge clk);
                if (done_seen) begin
                    check("busy_fall", o_busy, 0);
                    fin = 1'b1;
                end else begin
                    if (o_sample_vld) begin
                        if (nstr == 0) begin
                            check("first_lat", cyc - s, 3);
                            check("err_clr", o_len_err, 0);
                        end else begin
                            check("spacing", cyc - last_vld, v.sp);
                        end
                        check("sample", o_sample, exp_val(nstr % int'(v.len)));
                        last_vld = cyc;
                        nstr++;
                    end
                    if (o_done) begin
                        ndone++;
                        check("done_w_vld", {o_sample_vld, o_busy}, 2'b11);
                        done_seen = 1'b1;
                    end
                end
            end
            if (!fin) fail_now("run_timeout");
            check("strobes", nstr, exp_n);
            check("done_cnt", ndone, 1);
            check("loop_idx", o_loop_idx, exp_lp);
            check("sample_idx", o_sample_idx, v.len - 10'd1);
        end
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", o_busy, 0);
    endtask

    task automatic wr_collision();
        int          s;
        int          d;
        int          nv;
        logic [15:0] exp_s [4];
        exp_s[0] = exp_val(0);
        exp_s[1] = exp_val(1);
        exp_s[2] = exp_val(2);
        exp_s[3] = 16'hbeef;
        @(negedge clk);
        i_len = 10'd4; i_period = 16'd5; i_loop_cnt = 16'd1;
        i_start = 1'b1;
        i_abort = 1'b1;
        s  = cyc;
        nv = 0;
        for (int t = 0; t < 21; t++) begin
            @(negedge clk);
            d = cyc - s;
            if (d == 1) begin
                i_abort = 1'b0;
                check("start_wins", o_busy, 1);
            end
            if (d == 6) begin
                i_host_wr_req  = 1'b1;
                i_host_wr_addr = 9'd3;
                i_host_wr_data = 16'hbeef;
                #1;
                check("coll_noack", o_host_wr_ack, 0);
                check("coll_fetch", {o_ram_en, o_ram_we, o_ram_addr}, {2'b10, 9'd1});
            end
            if (d == 7) begin
                #1;
                check("coll_ack", {o_host_wr_ack, o_ram_en, o_ram_we, o_ram_addr, o_ram_din},
                      {3'b111, 9'd3, 16'hbeef});
            end
            if (d == 8) i_host_wr_req = 1'b0;
            check("coll_vld", o_sample_vld, (d == 3 || d == 8 || d == 13 || d == 18));
            if (o_sample_vld && nv < 4) begin
                check("coll_sample", o_sample, exp_s[nv]);
                nv++;
            end
            if (d == 18) check("coll_done", o_done, 1);
            if (d == 19) check("coll_busy", o_busy, 0);
        end
        i_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic abort_seq();
        int nv;
        int nd;
        int nb;
        @(negedge clk);
        i_len = 10'd4; i_period = 16'd5; i_loop_cnt = 16'd1;
        i_start = 1'b1;
        @(negedge clk);
        check("abort_fetch", {o_ram_en, o_ram_we}, 2'b10);
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        nv = 0; nd = 0; nb = 0;
        repeat (10) begin
            if (o_sample_vld) nv++;
            if (o_done) nd++;
            if (o_busy) nb++;
            @(negedge clk);
        end
        check("abort_novld", nv, 0);
        check("abort_nodone", nd, 0);
        check("abort_busy", nb, 0);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        i_len = 10'd4; i_period = 16'd5; i_loop_cnt = 16'd1;
        i_start = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_rst_busy", o_busy, 1);
        i_host_wr_req  = 1'b1;
        i_host_wr_addr = 9'd5;
        i_host_wr_data = 16'h1234;
        i_rst = 1'b0;
        #1;
        check("midrst_outs", w_outs, 96'd0);
        @(negedge clk);
        i_host_wr_req = 1'b0;
        i_start = 1'b0;
        i_rst = 1'b1;
        @(negedge clk);
        check("postrst_busy", o_busy, 0);
    endtask

    initial begin
        i_rst = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_len = '0;
        i_period = '0;
        i_loop_cnt = '0;
        i_host_wr_req = 1'b0;
        i_host_wr_addr = '0;
        i_host_wr_data = '0;

        vecs[0] = '{10'd4,   16'd5, 16'd1, 5, 1'b0};
        vecs[1] = '{10'd0,   16'd5, 16'd1, 5, 1'b1};
        vecs[2] = '{10'd4,   16'd1, 16'd1, 3, 1'b0};
        vecs[3] = '{10'd4,   16'd0, 16'd1, 3, 1'b0};
        vecs[4] = '{10'd513, 16'd5, 16'd1, 5, 1'b1};
        vecs[5] = '{10'd2,   16'd4, 16'd3, 4, 1'b0};
        vecs[6] = '{10'd1,   16'd3, 16'd2, 3, 1'b0};
        vecs[7] = '{10'd512, 16'd3, 16'd1, 3, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_outs", w_outs, 96'd0);
        i_rst = 1'b1;
        @(negedge clk);
        check("post_rst_outs", w_outs, 96'd0);

        for (int k = 0; k < 512; k++) host_write(k, exp_val(k), (k == 0));

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        wr_collision();
        host_write(3, exp_val(3), 1'b1);
        abort_seq();
        reset_mid_run();
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
